// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, request-error causes,
// access-counter width and the request legality helper.
package data_mem_responder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BOTH     = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_RANGE    = 2'd3
    } err_cause_e;

    localparam int ACCESS_CNT_W = 16;

    // Only meaningful when at least one of rd/wr is asserted.
    function automatic err_cause_e req_check(input logic        rd,
                                             input logic        wr,
                                             input logic [31:0] addr,
                                             input int          addr_w);
        if (rd && wr)
            return ERR_BOTH;
        if (addr[1:0] != 2'b00)
            return ERR_MISALIGN;
        if ((addr >> (addr_w + 2)) != 32'd0)
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU MEM-stage <-> data-memory bus. The CPU side is the master, the responder the slave.
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic                    MemoryRead;
    logic                    MemoryWrite;
    logic [31:0]             Address;
    logic [DATA_W-1:0]       WriteData;
    logic [DATA_W-1:0]       ReadData;
    logic                    ReadValid;
    logic                    Busy;
    logic                    Error;
    logic [ACCESS_CNT_W-1:0] AccessCount;

    modport master (
        output MemoryRead, MemoryWrite, Address, WriteData,
        input  ReadData, ReadValid, Busy, Error, AccessCount
    );

    modport slave (
        input  MemoryRead, MemoryWrite, Address, WriteData,
        output ReadData, ReadValid, Busy, Error, AccessCount
    );
endinterface

// File: rtl/data_mem_responder_wait_counter.sv
// Wait-state down-counter: load on accept, decrement while in flight, flag zero.
module data_mem_responder_wait_counter #(
    parameter int CNT_W = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK) begin
        if (Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: serves CPU loads/stores after WAIT_CYCLES wait states,
// stalls the pipeline via Busy, flags illegal requests and counts completed accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                CLK,
    input  logic                Reset,
    data_mem_responder_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e                  state_q, state_d;
    op_e                     op_q;
    logic [ADDR_W-1:0]       idx_q;
    logic [DATA_W-1:0]       data_q;
    logic                    err_q, err_d;
    logic [ACCESS_CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    // NOTE: the word array has no reset; contents survive Reset and cost no reset fan-out.
    logic [DATA_W-1:0]       mem_q [2**ADDR_W];

    logic        req_any, req_legal, req_illegal;
    logic        accept, complete, busy, cnt_zero;
    op_e         eff_op;
    logic [ADDR_W-1:0] eff_idx;
    logic [DATA_W-1:0] eff_data;

    assign req_any     = bus.MemoryRead || bus.MemoryWrite;
    assign req_legal   = req_any &&
                         (req_check(bus.MemoryRead, bus.MemoryWrite, bus.Address, ADDR_W) == ERR_NONE);
    assign req_illegal = req_any && !req_legal;

    data_mem_responder_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
        .CLK        (CLK),
        .Reset      (Reset),
        .load_i     (accept),
        .load_val_i (CNT_LOAD),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_legal && (WAIT_CYCLES > 0)) state_d = ST_WAIT;
            ST_WAIT: if (cnt_zero) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // In WAIT the latched request drives the datapath; in IDLE the live bus does.
    always_comb begin
        accept   = 1'b0;
        complete = 1'b0;
        busy     = 1'b0;
        eff_op   = op_q;
        eff_idx  = idx_q;
        eff_data = data_q;
        case (state_q)
            ST_IDLE: begin
                eff_op   = bus.MemoryWrite ? OP_WRITE : OP_READ;
                eff_idx  = bus.Address[ADDR_W+1:2];
                eff_data = bus.WriteData;
                if (req_legal) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        accept = 1'b1;
                        busy   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                busy     = !cnt_zero;
                complete = cnt_zero;
            end
            default: ;
        endcase
        err_d     = (state_q == ST_IDLE) && req_illegal;
        acc_cnt_d = (complete && (acc_cnt_q != '1)) ? acc_cnt_q + ACCESS_CNT_W'(1) : acc_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            op_q   <= eff_op;
            idx_q  <= eff_idx;
            data_q <= eff_data;
        end
    end

    // Gating with Reset drops a store whose completion edge coincides with reset.
    always_ff @(posedge CLK) begin
        if (!Reset && complete && (eff_op == OP_WRITE))
            mem_q[eff_idx] <= eff_data;
    end

    assign bus.Busy        = busy;
    assign bus.ReadValid   = complete && (eff_op == OP_READ);
    assign bus.ReadData    = bus.ReadValid ? mem_q[eff_idx] : '0;
    assign bus.Error       = err_q;
    assign bus.AccessCount = acc_cnt_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: one responder with two wait states and one single-cycle responder.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst2, rst0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   busy0_seen = 1'b0;
    bit   watch_busy0 = 1'b0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t rq2[$], rq0[$];
    int      eq2[$], eq0[$];

    data_mem_responder_if #(.DATA_W(32)) b2 ();
    data_mem_responder_if #(.DATA_W(32)) b0 ();

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) dut_w2 (
        .CLK(clk), .Reset(rst2), .bus(b2)
    );
    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .CLK(clk), .Reset(rst0), .bus(b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected reads/errors whenever a DUT presents one.
    always @(negedge clk) begin
        rd_exp_t e;
        if (b2.ReadValid) begin
            if (rq2.size() == 0) check("w2_unexpected_readvalid", 32'd1, 32'd0);
            else begin
                e = rq2.pop_front();
                check("w2_read_cycle", cyc, e.cyc);
                check("w2_read_data", b2.ReadData, e.data);
            end
        end
        if (b2.Error) begin
            if (eq2.size() == 0) check("w2_unexpected_error", 32'd1, 32'd0);
            else check("w2_error_cycle", cyc, eq2.pop_front());
        end
        if (b0.ReadValid) begin
            if (rq0.size() == 0) check("w0_unexpected_readvalid", 32'd1, 32'd0);
            else begin
                e = rq0.pop_front();
                check("w0_read_cycle", cyc, e.cyc);
                check("w0_read_data", b0.ReadData, e.data);
            end
        end
        if (b0.Error) begin
            if (eq0.size() == 0) check("w0_unexpected_error", 32'd1, 32'd0);
            else check("w0_error_cycle", cyc, eq0.pop_front());
        end
        if (watch_busy0 && b0.Busy) busy0_seen = 1'b1;
    end

    task automatic access2(input string name, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_busy, input logic exp_err, input logic [31:0] exp_data);
        int t;
        int busy_n;
        bit done;
        @(posedge clk); #1;
        b2.MemoryRead = rd; b2.MemoryWrite = wr; b2.Address = addr; b2.WriteData = wdata;
        t = cyc;
        if (exp_err) eq2.push_back(t + 1);
        else if (rd) rq2.push_back('{t + exp_busy, exp_data});
        busy_n = 0;
        done   = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (b2.Busy) busy_n++;
            else done = 1'b1;
        end
        check({name, "_busy_len"}, busy_n, exp_busy);
    endtask

    task automatic idle2(input int n);
        @(posedge clk); #1;
        b2.MemoryRead = 1'b0; b2.MemoryWrite = 1'b0; b2.Address = '0; b2.WriteData = '0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access0(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data);
        @(posedge clk); #1;
        b0.MemoryRead = rd; b0.MemoryWrite = wr; b0.Address = addr; b0.WriteData = wdata;
        if (rd) rq0.push_back('{cyc, exp_data});
        @(negedge clk);
    endtask

    task automatic idle0();
        @(posedge clk); #1;
        b0.MemoryRead = 1'b0; b0.MemoryWrite = 1'b0; b0.Address = '0; b0.WriteData = '0;
        @(negedge clk);
    endtask

    logic [31:0] t5_addr [4] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0080, 32'h0000_03FC};
    logic [31:0] t5_data [4] = '{32'h1234_5678, 32'h8765_4321, 32'h0F0F_0F0F, 32'hFFFF_0001};

    initial begin
        b2.MemoryRead = 1'b0; b2.MemoryWrite = 1'b0; b2.Address = '0; b2.WriteData = '0;
        b0.MemoryRead = 1'b0; b0.MemoryWrite = 1'b0; b0.Address = '0; b0.WriteData = '0;
        rst2 = 1'b1;
        rst0 = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", b2.Busy, 0);
        check("rst_readvalid", b2.ReadValid, 0);
        check("rst_readdata", b2.ReadData, 0);
        check("rst_error", b2.Error, 0);
        check("rst_acccount", b2.AccessCount, 0);
        check("rst0_acccount", b0.AccessCount, 0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        rst0 = 1'b0;

        // Write then read, two wait states each
        access2("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
        access2("rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
        idle2(1);
        check("acc_after_wr_rd", b2.AccessCount, 2);
        check("rdata_zero_when_idle", b2.ReadData, 0);
        access2("wr_00", 1'b0, 1'b1, 32'h00, 32'h1111_1111, 2, 1'b0, 32'h0);
        access2("wr_20", 1'b0, 1'b1, 32'h20, 32'h5A5A_5A5A, 2, 1'b0, 32'h0);

        // Illegal: misaligned, then both strobes
        access2("rd_misalign", 1'b1, 1'b0, 32'h12, 32'h0, 0, 1'b1, 32'h0);
        access2("rdwr_both", 1'b1, 1'b1, 32'h00, 32'h0000_0BAD, 0, 1'b1, 32'h0);
        idle2(2);
        check("acc_after_illegal", b2.AccessCount, 4);
        access2("rd_00_kept", 1'b1, 1'b0, 32'h00, 32'h0, 2, 1'b0, 32'h1111_1111);

        // Out of range, then the last legal word
        access2("rd_oor", 1'b1, 1'b0, 32'h400, 32'h0, 0, 1'b1, 32'h0);
        access2("wr_3fc", 1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 2, 1'b0, 32'h0);
        access2("rd_3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 2, 1'b0, 32'hCAFE_F00D);
        idle2(1);
        check("acc_after_range", b2.AccessCount, 7);

        // Reset during the first wait cycle of a write
        @(posedge clk); #1;
        b2.MemoryWrite = 1'b1; b2.Address = 32'h20; b2.WriteData = 32'h0000_0001;
        @(posedge clk); #1;
        rst2 = 1'b1;
        b2.MemoryWrite = 1'b0; b2.Address = '0; b2.WriteData = '0;
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(negedge clk);
        check("abort_busy", b2.Busy, 0);
        check("abort_acccount", b2.AccessCount, 0);
        access2("rd_20_old", 1'b1, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h5A5A_5A5A);
        access2("rd_10_kept", 1'b1, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
        idle2(1);
        check("acc_after_abort", b2.AccessCount, 2);

        // Zero wait states: write/read pairs, data returned in the same cycle
        watch_busy0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            access0(1'b0, 1'b1, t5_addr[i], t5_data[i], 32'h0);
            access0(1'b1, 1'b0, t5_addr[i], 32'h0, t5_data[i]);
        end
        idle0();
        watch_busy0 = 1'b0;
        check("w0_busy_never", {31'd0, busy0_seen}, 0);
        check("w0_acc_8", b0.AccessCount, 8);

        // Saturation: stream writes up to 0xFFFE, then three more accesses
        @(posedge clk); #1;
        b0.MemoryWrite = 1'b1; b0.Address = 32'h100; b0.WriteData = 32'h0000_0077;
        repeat (65526) @(posedge clk);
        #1;
        b0.MemoryWrite = 1'b0; b0.Address = '0; b0.WriteData = '0;
        @(negedge clk);
        check("w0_acc_fffe", b0.AccessCount, 32'h0000_FFFE);
        access0(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_0077);
        idle0();
        check("w0_acc_ffff", b0.AccessCount, 32'h0000_FFFF);
        access0(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_0077);
        access0(1'b0, 1'b1, 32'h104, 32'h0000_0099, 32'h0);
        idle0();
        check("w0_acc_hold", b0.AccessCount, 32'h0000_FFFF);

        // Everything expected must have been observed
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("w2_reads_drained", rq2.size(), 0);
        check("w2_errors_drained", eq2.size(), 0);
        check("w0_reads_drained", rq0.size(), 0);
        check("w0_errors_drained", eq0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
